// File: rtl/axis_mux_pkg.sv
// axis_mux_pkg: shared types and helpers for the N:1 packet-aware stream mux.
// Holds FSM state, arbitration mode encoding and select-width helper.
package axis_mux_pkg;

  typedef enum logic {
    IDLE,
    PASS
  } mux_state_e;

  typedef enum logic {
    ARB_SEL,
    ARB_RR
  } arb_mode_e;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: combinational round-robin pick among requesters.
// Scans from ptr+1 upward, wrapping modulo N; first requester wins.
module axis_rr_arbiter
  import axis_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [SELW-1:0] idx;

  // Walk offsets from far to near so the nearest hit is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SELW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_mux_n_1.sv
// axis_mux_n_1: packet-locked N:1 AXI-Stream mux with registered output.
// Source chosen by external sel or round-robin; held until tlast.
module axis_mux_n_1
  import axis_mux_pkg::*;
#(
  parameter int DW       = 8,
  parameter int N        = 4,
  parameter int SELW     = clog2_min1(N),
  parameter int ARB_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SELW-1:0] sel,
  input  logic [N*DW-1:0] s_tdata,
  input  logic [N-1:0]    s_tvalid,
  input  logic [N-1:0]    s_tlast,
  output logic [N-1:0]    s_tready,
  output logic [DW-1:0]   m_tdata,
  output logic            m_tvalid,
  output logic            m_tlast,
  input  logic            m_tready,
  output logic            busy,
  output logic [SELW-1:0] grant
);

  localparam arb_mode_e MODE =
    (ARB_MODE == 1) ? ARB_RR : ARB_SEL;

  mux_state_e      state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] pick_idx;
  logic            rr_vld;
  logic            pick_vld;
  logic            sel_ok;
  logic            out_rdy;
  logic            xfer;

  axis_rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req     (s_tvalid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign sel_ok  = (int'(sel) < N) && s_tvalid[sel];
  assign out_rdy = !m_tvalid || m_tready;
  assign busy    = (state == PASS);
  assign xfer    = busy && s_tvalid[grant] && out_rdy;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    if (MODE == ARB_RR) begin
      pick_vld = rr_vld;
      pick_idx = rr_idx;
    end else begin
      pick_vld = sel_ok;
      pick_idx = sel;
    end
  end

  always_comb begin
    s_tready = '0;
    if (busy) s_tready[grant] = out_rdy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= SELW'(N - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= PASS;
            grant <= pick_idx;
            if (MODE == ARB_RR) ptr <= pick_idx;
          end
        end
        PASS: begin
          if (xfer && s_tlast[grant]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single skid-free register stage; refills in the same cycle it drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (xfer) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata[int'(grant)*DW +: DW];
      m_tlast  <= s_tlast[grant];
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_mux_n_1.sv
// tb_axis_mux_n_1: three mux instances (sel N=4, rr N=4, sel N=5) on shared
// stimulus, each checked every cycle against a packet-level reference model.
module tb_axis_mux_n_1;

  typedef struct packed {
    int         own;
    int         grant;
    int         ptr;
    logic       mv;
    logic [7:0] md;
    logic       ml;
  } mdl_t;

  typedef struct packed {
    int         cyc;
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  v5;
  logic [4:0]  l5;
  logic [39:0] d40;
  logic [1:0]  sel_a;
  logic [2:0]  sel_c;
  logic        m_tready;

  logic [3:0] a_s_tready, b_s_tready;
  logic [4:0] c_s_tready;
  logic [7:0] a_m_tdata, b_m_tdata, c_m_tdata;
  logic       a_m_tvalid, b_m_tvalid, c_m_tvalid;
  logic       a_m_tlast, b_m_tlast, c_m_tlast;
  logic       a_busy, b_busy, c_busy;
  logic [1:0] a_grant, b_grant;
  logic [2:0] c_grant;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int a_busy_n = 0;
  beat_t qa[$];
  beat_t qb[$];
  int gq[$];

  axis_mux_n_1 #(.DW(8), .N(4), .ARB_MODE(0)) u_a (
    .clk(clk), .rst(rst), .sel(sel_a),
    .s_tdata(d40[31:0]), .s_tvalid(v5[3:0]), .s_tlast(l5[3:0]),
    .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast),
    .m_tready(m_tready), .busy(a_busy), .grant(a_grant)
  );

  axis_mux_n_1 #(.DW(8), .N(4), .ARB_MODE(1)) u_b (
    .clk(clk), .rst(rst), .sel(sel_a),
    .s_tdata(d40[31:0]), .s_tvalid(v5[3:0]), .s_tlast(l5[3:0]),
    .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast),
    .m_tready(m_tready), .busy(b_busy), .grant(b_grant)
  );

  axis_mux_n_1 #(.DW(8), .N(5), .ARB_MODE(0)) u_c (
    .clk(clk), .rst(rst), .sel(sel_c),
    .s_tdata(d40), .s_tvalid(v5), .s_tlast(l5),
    .s_tready(c_s_tready),
    .m_tdata(c_m_tdata), .m_tvalid(c_m_tvalid), .m_tlast(c_m_tlast),
    .m_tready(m_tready), .busy(c_busy), .grant(c_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h want %0h (cycle %0d)",
                 nm, act, exp, cyc);
    end
  endtask

  // Reference: a source owns the output from grant until its tlast beat
  // is taken; the output register holds one beat.
  function automatic mdl_t mreset(input int n);
    mdl_t m;
    m.own = -1; m.grant = 0; m.ptr = n - 1;
    m.mv = 1'b0; m.md = 8'h00; m.ml = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int n,
      input int mode, input int sel, input logic [4:0] v,
      input logic [4:0] l, input logic [39:0] d, input logic mr);
    mdl_t x = m;
    bit rdy = !m.mv || mr;
    bit found = 0;
    int c;
    if (m.own < 0) begin
      if (mr) x.mv = 1'b0;
      if (mode == 0) begin
        if (sel < n && v[sel]) begin
          x.own = sel; x.grant = sel;
        end
      end else begin
        for (int k = 1; k <= n; k++) begin
          c = (m.ptr + k) % n;
          if (!found && v[c]) begin
            found = 1; x.own = c; x.grant = c; x.ptr = c;
          end
        end
      end
    end else if (v[m.own] && rdy) begin
      x.mv = 1'b1;
      x.md = d[m.own*8 +: 8];
      x.ml = l[m.own];
      if (l[m.own]) x.own = -1;
    end else if (mr) begin
      x.mv = 1'b0;
    end
    return x;
  endfunction

  function automatic logic [4:0] mrdy(input mdl_t m, input logic mr);
    logic [4:0] r = '0;
    if (m.own >= 0) r[m.own] = !m.mv || mr;
    return r;
  endfunction

  task automatic cmp(input string tg, input mdl_t m, input logic bz,
      input int gr, input logic mv, input logic [7:0] md,
      input logic ml, input logic [4:0] sr);
    chk({tg, "_busy"}, bz, m.own >= 0);
    chk({tg, "_grant"}, gr, m.grant);
    chk({tg, "_m_tvalid"}, mv, m.mv);
    chk({tg, "_s_tready"}, sr, mrdy(m, m_tready));
    if (m.mv) begin
      chk({tg, "_m_tdata"}, md, m.md);
      chk({tg, "_m_tlast"}, ml, m.ml);
    end
  endtask

  initial begin
    mdl_t ma, mb, mc;
    logic pv = 1'b0, pr = 1'b1;
    logic [8:0] pd = '0;
    ma = mreset(4); mb = mreset(4); mc = mreset(5);
    forever begin
      @(negedge clk);
      if (!rst) begin
        ma = mreset(4); mb = mreset(4); mc = mreset(5);
      end
      cmp("A", ma, a_busy, int'(a_grant), a_m_tvalid, a_m_tdata,
          a_m_tlast, {1'b0, a_s_tready});
      cmp("B", mb, b_busy, int'(b_grant), b_m_tvalid, b_m_tdata,
          b_m_tlast, {1'b0, b_s_tready});
      cmp("C", mc, c_busy, int'(c_grant), c_m_tvalid, c_m_tdata,
          c_m_tlast, c_s_tready);
      if (rst && pv && !pr)
        chk("A_stall_hold", {a_m_tvalid, a_m_tdata, a_m_tlast},
            {1'b1, pd});
      pv = a_m_tvalid && rst;
      pr = m_tready;
      pd = {a_m_tdata, a_m_tlast};
      if (rst) begin
        ma = mstep(ma, 4, 0, int'(sel_a), v5, l5, d40, m_tready);
        mb = mstep(mb, 4, 1, int'(sel_a), v5, l5, d40, m_tready);
        mc = mstep(mc, 5, 0, int'(sel_c), v5, l5, d40, m_tready);
      end
    end
  end

  initial begin
    logic bq = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (a_m_tvalid && m_tready)
          qa.push_back('{cyc: cyc, d: a_m_tdata, l: a_m_tlast});
        if (b_m_tvalid && m_tready)
          qb.push_back('{cyc: cyc, d: b_m_tdata, l: b_m_tlast});
        if (b_busy && !bq) gq.push_back(int'(b_grant));
        a_busy_n += int'(a_busy);
      end
      bq = b_busy;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; v5 = '0; l5 = '0; m_tready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    qa.delete(); qb.delete(); gq.delete();
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input int ch, input int nb,
      input logic [7:0] base, input int sel_at, input int sel_new,
      input int gap_at, input bit bp);
    int k = 0, t = 0, g = 0;
    bit gapping;
    logic acc;
    while (k < nb && t < 300) begin
      gapping = (k == gap_at) && (g < 3);
      if (gapping) begin
        v5[ch] = 1'b0; g++;
      end else begin
        v5[ch] = 1'b1;
        d40[ch*8 +: 8] = base + 8'(k);
        l5[ch] = (k == nb - 1);
      end
      if (k == sel_at) sel_a = 2'(sel_new);
      m_tready = bp ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      @(negedge clk);
      acc = v5[ch] && a_s_tready[ch];
      if (gapping) chk("T6_gap_busy", a_busy, 1'b1);
      @(posedge clk); #1;
      if (acc) k++;
      t++;
    end
    v5[ch] = 1'b0; l5[ch] = 1'b0; m_tready = 1'b1;
    chk($sformatf("drive_done_ch%0d", ch), k, nb);
  endtask

  task automatic chk_seq(input string nm, input int nb,
                         input logic [7:0] base);
    chk({nm, "_count"}, qa.size(), nb);
    for (int i = 0; i < nb && i < qa.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), qa[i].d, base + 8'(i));
      chk($sformatf("%s_last%0d", nm, i), qa[i].l, i == nb - 1);
    end
  endtask

  initial begin
    int t0, nb0, cnt;
    int bc[4];
    logic [3:0] acc;
    logic [7:0] exp4 [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20,
                              8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    int expg [5] = '{0, 1, 2, 3, 0};
    v5 = '0; l5 = '0; d40 = '0; sel_a = '0; sel_c = '0;
    m_tready = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk("T1_init_mvalid", a_m_tvalid, 1'b0);
    chk("T1_init_busy", b_busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Sel mode, 4-beat packet on ch2, latency and rate.
    do_reset();
    sel_a = 2'd2;
    t0 = cyc;
    drive_pkt(2, 4, 8'h10, -1, 0, -1, 1'b0);
    drain();
    chk_seq("T2", 4, 8'h10);
    if (qa.size() >= 4) begin
      chk("T2_first_latency", qa[0].cyc - t0, 2);
      chk("T2_rate", qa[3].cyc - qa[0].cyc, 3);
    end

    // Sel changes mid-packet; ch1 waits for ch2's tlast.
    do_reset();
    sel_a = 2'd2;
    v5[1] = 1'b1; d40[15:8] = 8'hA0; l5[1] = 1'b1;
    drive_pkt(2, 6, 8'h30, 2, 1, -1, 1'b0);
    drive_pkt(1, 1, 8'hA0, -1, 1, -1, 1'b0);
    drain();
    chk("T3_count", qa.size(), 7);
    for (int i = 0; i < 6 && i < qa.size(); i++)
      chk($sformatf("T3_data%0d", i), qa[i].d, 8'h30 + 8'(i));
    if (qa.size() >= 7) begin
      chk("T3_ch1_after", qa[6].d, 8'hA0);
      chk("T3_last5", qa[5].l, 1'b1);
    end

    // Round-robin, all channels valid with 2-beat packets.
    do_reset();
    bc = '{0, 0, 0, 0};
    cnt = 0;
    while (qb.size() < 10 && cnt < 200) begin
      for (int ch = 0; ch < 4; ch++) begin
        v5[ch] = (bc[ch] < 4);
        d40[ch*8 +: 8] = 8'(ch * 16 + bc[ch]);
        l5[ch] = (bc[ch] % 2 == 1);
      end
      @(negedge clk);
      acc = v5[3:0] & b_s_tready;
      @(posedge clk); #1;
      for (int ch = 0; ch < 4; ch++) if (acc[ch]) bc[ch]++;
      cnt++;
    end
    v5 = '0; l5 = '0;
    chk("T4_count", qb.size(), 10);
    for (int i = 0; i < 10 && i < qb.size(); i++)
      chk($sformatf("T4_data%0d", i), qb[i].d, exp4[i]);
    for (int i = 0; i < 5; i++)
      chk($sformatf("T4_grant%0d", i),
          (i < gq.size()) ? gq[i] : -1, expg[i]);

    // Backpressure 1,0,0,1 during an 8-beat packet.
    do_reset();
    sel_a = 2'd0;
    drive_pkt(0, 8, 8'h50, -1, 0, -1, 1'b1);
    drain();
    chk_seq("T5", 8, 8'h50);

    // Single-beat packet holds busy for one cycle.
    do_reset();
    sel_a = 2'd3;
    nb0 = a_busy_n;
    drive_pkt(3, 1, 8'h77, -1, 3, -1, 1'b0);
    drain();
    chk("T6_single_busy", a_busy_n - nb0, 1);
    chk_seq("T6s", 1, 8'h77);

    // Granted source pauses for 3 cycles mid-packet.
    do_reset();
    sel_a = 2'd1;
    drive_pkt(1, 4, 8'h60, -1, 1, 2, 1'b0);
    drain();
    chk_seq("T6g", 4, 8'h60);

    // sel beyond channel count never grants.
    do_reset();
    sel_c = 3'd5;
    v5 = '1; l5 = '1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(c_busy) + int'(c_m_tvalid);
      @(posedge clk); #1;
    end
    chk("T6_sel5_nogrant", cnt, 0);
    v5 = '0; l5 = '0;

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      v5 = 5'($urandom) | 5'($urandom);
      l5 = 5'($urandom) & 5'($urandom);
      d40 = {$urandom, 8'($urandom)};
      sel_a = 2'($urandom);
      sel_c = 3'($urandom_range(0, 7));
      m_tready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) != 0);
      if (i == 800) begin
        rst = 1'b0;
        @(negedge clk);
        chk("T1_mid_mvalid", a_m_tvalid, 1'b0);
        chk("T1_mid_sready", {a_s_tready, b_s_tready}, 8'h00);
        chk("T1_mid_busy", {a_busy, b_busy}, 2'b00);
        chk("T1_mid_grant", {a_grant, b_grant}, 4'h0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
